// File: rtl/mips_core_pkg.sv
// Shared definitions for the miss arbiter slice.
//   miss_state_e   : arbiter FSM state encoding
//   NUM_THREADS    : hardware threads sharing the memory port
//   REQ_PER_THREAD : miss requesters per thread (I-side, D-side)
//   req_thread()   : requester index -> owning thread
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package mips_core_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } miss_state_e;

    localparam int NUM_THREADS    = 2;
    localparam int REQ_PER_THREAD = 2;
    localparam int THREAD_W       = $clog2(NUM_THREADS);

    // Requesters are laid out thread-major: 0/1 -> T0, 2/3 -> T1.
    function automatic logic [THREAD_W-1:0] req_thread(input int r);
        return THREAD_W'(r / REQ_PER_THREAD);
    endfunction

endpackage

// File: rtl/thread_miss_arbiter_rr_picker.sv
// Round-robin selector: picks the first asserted request after ptr.
//   req   : request vector
//   ptr   : last served index (scan starts at ptr+1)
//   grant : one-hot grant
//   idx   : binary index of grant
//   any   : at least one request asserted
module rr_picker #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic          found;
    logic [IW-1:0] pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 1; k <= N; k++) begin
            pos = IW'((int'(ptr) + k) % N);
            if (!found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                idx        = pos;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/thread_miss_arbiter.sv
// Shares one memory port between per-thread I/D miss requesters with
// round-robin fairness, one transaction outstanding and a response watchdog.
//   req_valid/req_addr/req_we : per-requester miss requests (held until req_ready)
//   req_ready                 : one-cycle acceptance pulse
//   resp_valid/resp_err       : response beats / timeout abort pulse to owner
//   mem_req_*                 : shared memory request (valid/ready handshake)
//   mem_resp_valid/_last      : response beats from memory
//   thread_mem_busy           : per-thread busy for thread switching
//   err_timeout               : sticky watchdog flag
//
// state    | meaning
// ST_IDLE  | no transaction; arbitrate among pending requesters
// ST_ISSUE | presenting latched request to memory until accepted
// ST_WAIT  | forwarding response beats; watchdog running
module thread_miss_arbiter
    import mips_core_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = `ADDR_WIDTH,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0]        req_we,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [NUM_REQ-1:0]        resp_err,
    output logic                      mem_req_valid,
    output logic [ADDR_W-1:0]         mem_req_addr,
    output logic                      mem_req_we,
    input  logic                      mem_req_ready,
    input  logic                      mem_resp_valid,
    input  logic                      mem_resp_last,
    output logic [1:0]                thread_mem_busy,
    output logic                      err_timeout
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    miss_state_e          state_q, state_d;
    logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 we_q, we_d;
    logic                 err_q, err_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0]   resp_err_q, resp_err_d;

    logic [NUM_REQ-1:0]   pick_grant;
    logic [IW-1:0]        pick_idx;
    logic                 pick_any;
    logic [NUM_THREADS-1:0] busy_raw;

    rr_picker #(.N(NUM_REQ)) u_rr_picker (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        we_d        = we_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        req_ready_d = '0;
        resp_err_d  = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    req_ready_d = pick_grant;
                    idx_d       = pick_idx;
                    addr_d      = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                    we_d        = req_we[pick_idx];
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_resp_valid) begin
                    cnt_d = '0;
                    if (mem_resp_last) begin
                        rr_ptr_d = idx_q;
                        state_d  = ST_IDLE;
                    end
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    // This idle cycle brings the count to TIMEOUT: abort.
                    cnt_d             = '0;
                    err_d             = 1'b1;
                    resp_err_d[idx_q] = 1'b1;
                    rr_ptr_d          = idx_q;
                    state_d           = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= IW'(NUM_REQ - 1);
            idx_q       <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            req_ready_q <= '0;
            resp_err_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            idx_q       <= idx_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            resp_err_q  <= resp_err_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign resp_err      = resp_err_q;
    assign err_timeout   = err_q;
    assign mem_req_valid = (state_q == ST_ISSUE);
    assign mem_req_addr  = (state_q == ST_ISSUE) ? addr_q : '0;
    assign mem_req_we    = (state_q == ST_ISSUE) & we_q;

    always_comb begin
        resp_valid = '0;
        if (state_q == ST_WAIT) resp_valid[idx_q] = mem_resp_valid;
    end

    // The requester being served may still hold req_valid during its ready
    // pulse; it is covered by the serving term, not counted as pending.
    always_comb begin
        busy_raw = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && !(state_q != ST_IDLE && idx_q == IW'(i)))
                busy_raw[req_thread(i)] = 1'b1;
        end
        if (state_q != ST_IDLE) busy_raw[req_thread(int'(idx_q))] = 1'b1;
    end

    // Busy follows req_valid combinationally; hold it low while in reset.
    assign thread_mem_busy = busy_raw & {NUM_THREADS{rst_n}};

endmodule

// File: doc/thread_miss_arbiter.md
THREAD_MISS_ARBITER -- requirements
Module: thread_miss_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of miss requesters; requester i belongs to thread i>>1 (0: T0 I-side, 1: T0 D-side, 2: T1 I-side, 3: T1 D-side).
REQ-002 SHALL have parameter ADDR_W, default `ADDR_WIDTH, request address width.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum idle cycles between response beats.
REQ-004 SHALL have port clk, in, 1, sole clock; one clock, all state on its rising edge.
REQ-005 SHALL have port rst_n, in, 1, reset; asynchronous, active-low.
REQ-006 SHALL have port req_valid, in, NUM_REQ, per-requester miss request; held until accepted.
REQ-007 SHALL have port req_addr, in, NUM_REQ*ADDR_W, packed per-requester addresses, slice i = requester i.
REQ-008 SHALL have port req_we, in, NUM_REQ, per-requester write flag.
REQ-009 SHALL have port req_ready, out, NUM_REQ, one-cycle acceptance pulse.
REQ-010 SHALL have port resp_valid, out, NUM_REQ, per-requester response beat strobe.
REQ-011 SHALL have port resp_err, out, NUM_REQ, one-cycle timeout-abort pulse.
REQ-012 SHALL have port mem_req_valid / mem_req_addr / mem_req_we, out, 1 / ADDR_W / 1, shared memory request.
REQ-013 SHALL have port mem_req_ready, in, 1, memory accepts request.
REQ-014 SHALL have port mem_resp_valid / mem_resp_last, in, 1 / 1, response beat / final beat.
REQ-015 SHALL have port thread_mem_busy, out, 2, per-thread busy to the thread switch logic.
REQ-016 SHALL have port err_timeout, out, 1, sticky timeout flag.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT; at most one memory transaction outstanding.
REQ-018 In IDLE with any req_valid, SHALL grant the first asserted requester scanning from rr_ptr+1 modulo NUM_REQ, pulse req_ready[grant], latch index/addr/we, and enter ISSUE next cycle.
REQ-019 In ISSUE SHALL drive mem_req_valid=1 with latched addr/we, held stable until mem_req_ready; on mem_req_valid&mem_req_ready enter WAIT.
REQ-020 In WAIT resp_valid[idx] SHALL equal mem_resp_valid combinationally; all other resp_valid bits 0.
REQ-021 On mem_resp_valid&mem_resp_last in WAIT SHALL set rr_ptr=idx and return to IDLE; new grant earliest the following cycle (one bubble).
REQ-022 Watchdog counter SHALL clear on entering WAIT and on each beat, increment otherwise; on reaching TIMEOUT SHALL pulse resp_err[idx], set err_timeout, set rr_ptr=idx, return to IDLE.
REQ-023 Counter width SHALL be $clog2(TIMEOUT+1); no wrap occurs before abort.
REQ-024 mem_resp_valid outside WAIT SHALL be ignored.
REQ-025 thread_mem_busy[t] SHALL be 1 when the FSM is non-IDLE serving a thread-t requester, or any thread-t req_valid is pending un-granted.
REQ-026 Deasserting req_valid for an un-granted requester SHALL cancel it without side effects.
REQ-027 err_timeout SHALL clear only on reset.

Reset
REQ-028 Asserting rst_n low SHALL immediately force IDLE, rr_ptr=NUM_REQ-1, counter=0, err_timeout=0, and all outputs 0, including mid-transaction.
REQ-029 First grant after reset SHALL go to requester 0 when it is requesting.

Structure
REQ-030 State enum and requester-to-thread mapping constants SHALL reside in the shared mips_core package.
REQ-031 The round-robin selector SHALL be a sub-module rr_picker (inputs request vector and pointer, outputs one-hot grant and index).

Verification
REQ-032 After reset, req_valid=4'b1111 -> grant order 0,1,2,3,0 over five transactions; req_ready single-cycle each.
REQ-033 Requester 1 only, addr 0x100, mem_req_ready delayed 3 cycles -> mem_req_addr=0x100 stable 4 cycles; 4-beat response -> resp_valid[1] 4 pulses, IDLE after last.
REQ-034 No mem_resp_valid for 255 cycles in WAIT on requester 2 -> resp_err[2] pulse, err_timeout=1, thread_mem_busy[1] drops unless requester 3 is pending.
REQ-035 rst_n low during WAIT -> mem_req_valid and resp_valid 0 same cycle; next grant goes to requester 0.
REQ-036 Stray mem_resp_valid in IDLE -> no resp_valid; request from requester 3 while requester 0 busy -> thread_mem_busy=2'b11.
